// File: rtl/clk_period_checker.sv
// Measures period and high time of a divided clock sampled in the clk domain,
// tracks lock against expected values. Optional input synchronizer: CLKCHK_SYNC_EN.
module clk_period_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             s_s;
  logic             s_q_r;
  logic             rise_s;
  logic             meas_s;
  logic             timeout_s;
  logic             match_s;
  logic             err_set_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [3:0]       lock_cnt_r;
  logic [3:0]       lock_inc_s;

`ifdef CLKCHK_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // two-flop synchronizer for a div_in from an unrelated domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= div_in;
      sync2_r <= sync1_r;
    end
  end

  assign s_s = sync2_r;
`else
  assign s_s = div_in;
`endif

  // previous sample for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q_r <= 1'b0;
    end else begin
      s_q_r <= s_s;
    end
  end

  assign rise_s = s_s & ~s_q_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state plus measurement/timeout strobes
  always_comb begin
    state_nxt_s = state_r;
    meas_s      = 1'b0;
    timeout_s   = 1'b0;
    if (!en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = ARM;
        end
        ARM: begin
          if (rise_s) begin
            state_nxt_s = MEASURE;
          end else begin
            state_nxt_s = ARM;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            meas_s      = 1'b1;
            state_nxt_s = MEASURE;
          end else if (cnt_r == CNT_MAX) begin
            timeout_s   = 1'b1;
            state_nxt_s = ARM;
          end else begin
            state_nxt_s = MEASURE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // compare the values about to be published against the expected ones
  always_comb begin
    match_s = (cnt_r == exp_period) && (hcnt_r == exp_high);
    if (lock_cnt_r == LOCK_VAL) begin
      lock_inc_s = lock_cnt_r;
    end else begin
      lock_inc_s = lock_cnt_r + 4'd1;
    end
    err_set_s = (meas_s & ~match_s) | timeout_s;
  end

  // counters, published measurement, lock tracking and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= CNT_ZERO;
      hcnt_r     <= CNT_ZERO;
      lock_cnt_r <= 4'd0;
      period     <= CNT_ZERO;
      high_time  <= CNT_ZERO;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= meas_s;
      // a new error takes priority over a simultaneous clear
      if (err_set_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end else begin
        err <= err;
      end
      if (!en) begin
        cnt_r      <= CNT_ZERO;
        hcnt_r     <= CNT_ZERO;
        lock_cnt_r <= 4'd0;
        locked     <= 1'b0;
      end else if (meas_s) begin
        period    <= cnt_r;
        high_time <= hcnt_r;
        cnt_r     <= CNT_ONE;
        hcnt_r    <= CNT_ONE;
        if (match_s) begin
          lock_cnt_r <= lock_inc_s;
          locked     <= (lock_inc_s == LOCK_VAL);
        end else begin
          lock_cnt_r <= 4'd0;
          locked     <= 1'b0;
        end
      end else if (timeout_s) begin
        cnt_r      <= CNT_ZERO;
        hcnt_r     <= CNT_ZERO;
        lock_cnt_r <= 4'd0;
        locked     <= 1'b0;
      end else if ((state_r == ARM) && rise_s) begin
        cnt_r  <= CNT_ONE;
        hcnt_r <= CNT_ONE;
      end else if (state_r == MEASURE) begin
        cnt_r  <= cnt_r + CNT_ONE;
        hcnt_r <= hcnt_r + {{(CNT_W-1){1'b0}}, s_s};
      end else begin
        cnt_r  <= cnt_r;
        hcnt_r <= hcnt_r;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_checker.sv
// Table-driven bench for clk_period_checker with a measurement scoreboard;
// honours CLKCHK_SYNC_EN by expecting two extra cycles of latency.
module tb_clk_period_checker;

  localparam int CNT_W = 8;
  localparam int LOCK  = 4;
`ifdef CLKCHK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             en         = 1'b0;
  logic             div_in     = 1'b0;
  logic             err_clr    = 1'b0;
  logic [CNT_W-1:0] exp_period = 8'd0;
  logic [CNT_W-1:0] exp_high   = 8'd0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err;

  clk_period_checker #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in),
    .exp_period(exp_period), .exp_high(exp_high), .err_clr(err_clr),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .err(err)
  );

  // one row: waveform + expected settings, then expected outputs at the row's last measurement
  typedef struct {
    int per; int hi; int nper; int ep; int eh; bit restart; bit clr;
    int mp; int mh; bit mlk; bit mer;
  } vec_t;

  typedef struct {
    int p; int h; bit lk; bit er; int cyc; int row;
  } meas_t;

  vec_t  vecs[10];
  meas_t sbq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int cnt_m   = 0;
  int hcnt_m  = 0;
  int run     = 0;
  int row_tag = -1;
  bit armed   = 1'b0;
  bit err_m   = 1'b0;
  bit prev    = 1'b0;

  logic             en_nxt  = 1'b0;
  logic             clr_nxt = 1'b0;
  logic [CNT_W-1:0] ep_nxt  = 8'd0;
  logic [CNT_W-1:0] eh_nxt  = 8'd0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_meas();
    meas_t e;
    bit    m;
    m = (cnt_m == int'(exp_period)) && (hcnt_m == int'(exp_high));
    if (m) begin
      if (run < LOCK) run++;
    end else begin
      run   = 0;
      err_m = 1'b1;
    end
    e.p   = cnt_m;
    e.h   = hcnt_m;
    e.lk  = (run == LOCK);
    e.er  = err_m;
    e.cyc = cyc + 1 + LAT;
    e.row = row_tag;
    row_tag = -1;
    sbq.push_back(e);
  endtask

  // one clk cycle of stimulus; the behavioural model follows the driven waveform
  task automatic step(input logic b);
    @(posedge clk);
    #1;
    en         = en_nxt;
    err_clr    = clr_nxt;
    exp_period = ep_nxt;
    exp_high   = eh_nxt;
    div_in     = b;
    if (!en) begin
      armed = 1'b0;
      run   = 0;
    end else if (b && !prev) begin
      if (armed) push_meas();
      else armed = 1'b1;
      cnt_m  = 1;
      hcnt_m = 1;
    end else if (armed) begin
      if (cnt_m == 255) begin
        armed = 1'b0;
        run   = 0;
        err_m = 1'b1;
      end else begin
        cnt_m++;
        if (b) hcnt_m++;
      end
    end
    prev = b;
  endtask

  task automatic run_row(input int r);
    vec_t v;
    v = vecs[r];
    if (v.restart) begin
      repeat (3) step(1'b0);
      en_nxt  = 1'b0;
      clr_nxt = v.clr;
      step(1'b0);
      clr_nxt = 1'b0;
      if (v.clr) err_m = 1'b0;
      ep_nxt = 8'(v.ep);
      eh_nxt = 8'(v.eh);
      repeat (3) step(1'b0);
      en_nxt = 1'b1;
      repeat (4) step(1'b0);
    end else begin
      ep_nxt = 8'(v.ep);
      eh_nxt = 8'(v.eh);
    end
    for (int k = 0; k < v.nper; k++) begin
      for (int j = 0; j < v.per; j++) begin
        if ((k == v.nper - 1) && (j == 0)) row_tag = r;
        step(j < v.hi);
      end
    end
  endtask

  // scoreboard: every meas_valid pulse must match the oldest expected measurement
  always @(negedge clk) begin : monitor
    meas_t e;
    if (rst_n && meas_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas: got meas_valid at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("meas_period", period, e.p);
        chk("meas_high", high_time, e.h);
        chk("meas_locked", locked, e.lk);
        chk("meas_err", err, e.er);
        chk("meas_cycle", cyc, e.cyc);
        if (e.row >= 0) begin
          chk($sformatf("row%0d_period", e.row), period, vecs[e.row].mp);
          chk($sformatf("row%0d_high", e.row), high_time, vecs[e.row].mh);
          chk($sformatf("row%0d_locked", e.row), locked, vecs[e.row].mlk);
          chk($sformatf("row%0d_err", e.row), err, vecs[e.row].mer);
        end
      end
    end
  end

  initial begin
    //          per hi nper ep eh rst clr  mp mh lk er
    vecs[0] = '{2, 1, 8, 2, 1, 1'b1, 1'b0, 2, 1, 1'b1, 1'b0};
    vecs[1] = '{3, 1, 8, 3, 1, 1'b1, 1'b0, 3, 1, 1'b1, 1'b0};
    vecs[2] = '{3, 1, 2, 4, 1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b1};
    vecs[3] = '{3, 1, 6, 3, 1, 1'b0, 1'b0, 3, 1, 1'b1, 1'b1};
    vecs[4] = '{4, 2, 8, 4, 2, 1'b1, 1'b1, 4, 2, 1'b1, 1'b0};
    vecs[5] = '{4, 2, 6, 4, 2, 1'b0, 1'b0, 4, 2, 1'b1, 1'b1};
    vecs[6] = '{8, 4, 6, 8, 4, 1'b1, 1'b0, 8, 4, 1'b1, 1'b1};
    vecs[7] = '{8, 4, 6, 8, 4, 1'b0, 1'b0, 8, 4, 1'b1, 1'b0};
    vecs[8] = '{4, 2, 6, 4, 2, 1'b1, 1'b0, 4, 2, 1'b1, 1'b0};
    vecs[9] = '{4, 2, 5, 4, 2, 1'b1, 1'b0, 4, 2, 1'b1, 1'b0};

    #12;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 5; r++) run_row(r);

    // hold div_in low: no premature timeout, then timeout drops lock and sets err
    repeat (240) step(1'b0);
    @(negedge clk);
    chk("pre_timeout_locked", locked, 1);
    chk("pre_timeout_err", err, 0);
    repeat (60) step(1'b0);
    @(negedge clk);
    chk("timeout_locked", locked, 0);
    chk("timeout_err", err, 1);

    run_row(5);
    run_row(6);

    // mismatch and err_clr in the same cycle, then err_clr alone
    for (int i = 0; i < 8; i++) begin
      ep_nxt  = (i <= LAT) ? 8'd5 : 8'd8;
      clr_nxt = (i == LAT) || (i == LAT + 1);
      step(i < 4);
    end
    clr_nxt = 1'b0;
    err_m   = 1'b0;
    @(negedge clk);
    chk("clr_alone_err", err, 0);
    chk("collision_locked", locked, 0);

    run_row(7);

    // disable while locked
    en_nxt = 1'b0;
    step(1'b0);
    @(negedge clk);
    chk("pre_dis_locked", locked, 1);
    step(1'b0);
    @(negedge clk);
    chk("dis_locked", locked, 0);
    chk("dis_period_hold", period, 8);
    chk("dis_high_hold", high_time, 4);

    run_row(8);

    // asynchronous reset in the middle of a period
    chk("pre_rst_period", period, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_period", period, 0);
    chk("async_rst_high", high_time, 0);
    chk("async_rst_meas_valid", meas_valid, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err", err, 0);
    chk("pre_rst_queue", sbq.size(), 0);
    armed  = 1'b0;
    run    = 0;
    err_m  = 1'b0;
    cnt_m  = 0;
    hcnt_m = 0;
    prev   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_row(9);

    repeat (6) step(1'b0);
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_period_checker.md
Name: clk_period_checker

Overview:
- Downstream monitor for the divided-clock outputs of the clock divider (e.g. div-by-2/3/4 taps).
- Samples one divided clock in the clk domain and measures its period and high time in clk cycles.
- Compares each measurement against expected values; reports lock after N consecutive matches, and a sticky error on mismatch or missing edges.
- Used for bring-up and run-time checking of generated clocks.

Parameters:
- CNT_W, 8: width of the period and high-time counters and expected-value inputs.
- LOCK_CNT, 4: consecutive matching measurements required to assert locked (1..15).

Ports:
- clk  in  1  system clock; the divided clock is generated from it.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable monitoring; 0 forces IDLE.
- div_in  in  1  divided clock under test, sampled on posedge clk.
- exp_period  in  CNT_W  expected period in clk cycles.
- exp_high  in  CNT_W  expected high time in clk cycles.
- err_clr  in  1  clears the sticky err flag.
- period  out  CNT_W  last measured period.
- high_time  out  CNT_W  last measured high time.
- meas_valid  out  1  one-cycle pulse when period/high_time update.
- locked  out  1  LOCK_CNT consecutive matches seen.
- err  out  1  sticky: mismatch or timeout.

Behaviour:
- Reset: on rst_n low, all outputs and internal state are 0 immediately (async); FSM goes to IDLE.
- Sampling: s = div_in; s_q = s registered; rise = s & ~s_q.
- FSM states:
  - IDLE: leave when en=1, go to ARM.
  - ARM: wait for the first rise. On rise: cnt<=1, hcnt<=1, go to MEASURE. No measurement is produced for this first edge.
  - MEASURE, on rise: period<=cnt, high_time<=hcnt, meas_valid<=1 next cycle, cnt<=1, hcnt<=1.
  - MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+1 if s=1.
- en=0 in any state: go to IDLE next cycle. cnt, hcnt and the lock counter clear; locked<=0; meas_valid<=0. period, high_time and err hold.
- Timeout: if cnt reaches all-ones in MEASURE with no rise, then err<=1, locked<=0, lock counter<=0, and the FSM returns to ARM. No meas_valid is generated.
- Comparison on each measurement: match = (period==exp_period) && (high_time==exp_high), evaluated on the new values.
  - Match: lock counter increments, saturating at LOCK_CNT. locked=1 while the counter equals LOCK_CNT.
  - Mismatch: lock counter<=0, locked<=0, err<=1.
- err stays set until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Expected values are sampled at measurement time; changing them mid-period is legal.
- Constant div_in never produces a rise, so the timeout fires. exp_period=0 never matches.
- Reference patterns:
  - div-by-2 (toggle every clk): period=2, high=1.
  - div-by-3 (high 1 of 3): period=3, high=1.
  - div-by-4: period=4, high=2.

Optional Feature:
- Macro: CLKCHK_SYNC_EN.
- Defined: s comes from a 2-flop synchronizer on div_in (reset to 0). All edge detection and meas_valid pulses are delayed by 2 clk cycles. Measured values are unchanged. Use this when div_in comes from an unrelated clock domain.
- Undefined: s = div_in directly, with no added latency.

Test Plan:
- Div-by-2 stimulus, exp 2/1, en=1: meas_valid pulses every 2 cycles, starting after the second rise; period=2, high_time=1; locked=1 on the 4th meas_valid; err=0.
- Div-by-3 (1 high, 2 low), exp 3/1 until locked, then exp_period<-4: next meas_valid gives period=3, err=1, locked=0. Restore exp_period=3: relock after 4 matches, err stays 1.
- Div-by-4 locked at exp 4/2, then hold div_in=0: after cnt reaches 255, err=1, locked=0, FSM in ARM. Resume toggling: first meas_valid after the second rise, and locked after 4 matches.
- err_clr asserted in the same cycle as a mismatch: err stays 1. err_clr alone next cycle: err=0.
- Reset and disable:
  - rst_n pulsed low mid-period: all outputs 0 without a clk edge; after release, no meas_valid until two rises have been seen.
  - en=0 while locked: locked=0 next cycle; period/high_time hold.
- With CLKCHK_SYNC_EN defined, rerun div-by-2: identical period/high_time values, and each meas_valid occurs exactly 2 cycles later than in the baseline run.
